// File: rtl/axi4_master_write_engine_if.sv
// Signal bundle of the AXI4 write engine: command and source inputs, completion
// report, and the AXI4 AW/W/B channels. master = engine view, slave = issuer/AXI slave view.
interface axi4_master_write_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [ID_WIDTH-1:0]     cmd_id;
    logic [7:0]              cmd_len;
    logic                    src_valid;
    logic                    src_ready;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [DATA_WIDTH/8-1:0] src_strb;
    logic                    done;
    logic [1:0]              done_resp;
    logic [ID_WIDTH-1:0]     done_id;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [ID_WIDTH-1:0]     AWID;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_id, cmd_len,
        input  src_valid, src_data, src_strb,
        input  AWREADY, WREADY, BVALID, BID, BRESP,
        output cmd_ready, src_ready, done, done_resp, done_id,
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST, BREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_id, cmd_len,
        output src_valid, src_data, src_strb,
        output AWREADY, WREADY, BVALID, BID, BRESP,
        input  cmd_ready, src_ready, done, done_resp, done_id,
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST, BREADY
    );
endinterface

// File: rtl/axi4_master_write_engine.sv
// AXI4 write master: one INCR burst per command, W beats streamed straight from
// the source, completion reported as a one-cycle pulse once the B response arrives.
module axi4_master_write_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input logic                        CLK,
    input logic                        RST,
    axi4_master_write_engine_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beats_left_q, beats_left_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  done_q, done_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic [ID_WIDTH-1:0]   done_id_q, done_id_d;
    logic                  w_hs;

    assign w_hs = (state_q == S_DATA) && bus.src_valid && bus.WREADY;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        id_d         = id_q;
        len_d        = len_q;
        beats_left_d = beats_left_q;
        done_d       = 1'b0;
        done_resp_d  = done_resp_q;
        done_id_d    = done_id_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d       = bus.cmd_addr;
                    id_d         = bus.cmd_id;
                    len_d        = bus.cmd_len;
                    beats_left_d = bus.cmd_len;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.AWREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (w_hs) begin
                    if (beats_left_q == '0) state_d = S_RESP;
                    else                    beats_left_d = beats_left_q - 8'd1;
                end
            end
            S_RESP: begin
                if (bus.BVALID) begin
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    // a response tagged with a foreign ID is reported as SLVERR
                    done_resp_d = (bus.BID != id_q) ? 2'b10 : bus.BRESP;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // registered so it stays low through reset and rises one cycle after
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            id_q         <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            cmd_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            done_resp_q  <= '0;
            done_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            len_q        <= len_d;
            beats_left_q <= beats_left_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            done_resp_q  <= done_resp_d;
            done_id_q    <= done_id_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.AWVALID   = (state_q == S_ADDR);
    assign bus.AWADDR    = addr_q;
    assign bus.AWID      = id_q;
    assign bus.AWLEN     = len_q;
    assign bus.AWSIZE    = 3'($clog2(DATA_WIDTH / 8));
    assign bus.AWBURST   = 2'b01;
    assign bus.WVALID    = (state_q == S_DATA) && bus.src_valid;
    assign bus.src_ready = (state_q == S_DATA) && bus.WREADY;
    assign bus.WDATA     = bus.src_data;
    assign bus.WSTRB     = bus.src_strb;
    assign bus.WLAST     = (state_q == S_DATA) && (beats_left_q == '0);
    assign bus.BREADY    = (state_q == S_RESP);
    assign bus.done      = done_q;
    assign bus.done_resp = done_resp_q;
    assign bus.done_id   = done_id_q;
endmodule

// File: tb/tb_axi4_master_write_engine.sv
// Self-checking bench for axi4_master_write_engine: table of directed bursts with
// hand-computed results, plus reset sequences in the AW, W and B phases.
module tb_axi4_master_write_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam int unsigned NVEC = 9;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    axi4_master_write_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi4_master_write_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [IW-1:0] bid;
        logic [1:0]    bresp;
        bit            stall;
        bit            junk_cmd;
        int unsigned   exp_beats;
        int unsigned   exp_lat;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs[NVEC];
    int unsigned nchecks = 0;
    int unsigned nerrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen_data(input int unsigned vi, input int unsigned k);
        return {8'(vi), 8'h5A, 16'(k * 3 + 32'h1000)};
    endfunction

    function automatic logic [SW-1:0] gen_strb(input int unsigned vi, input int unsigned k);
        return SW'(k + vi * 3);
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_id    = '0;
        bus.cmd_len   = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.src_strb  = '0;
        bus.AWREADY   = 1'b0;
        bus.WREADY    = 1'b0;
        bus.BVALID    = 1'b0;
        bus.BID       = '0;
        bus.BRESP     = '0;
    endtask

    // Inputs change 1 time unit after a rising edge; everything is observed on the
    // falling edge, where a valid&ready pair means a transfer at the next rising edge.
    task automatic run_burst(input int unsigned vi);
        vec_t v;
        int unsigned len_i, cyc, lat, done_lat, beats, sidx, aw_cnt, dones;
        int unsigned aw_bad, w_bad, data_bad, last_bad, rdy_bad, b_bad;
        bit started, aw_done, aw_pend, aw_hs, w_hs, src_hs, b_hs, b_done, finished, in_data;
        logic [AW-1:0] snap_addr;
        logic [IW-1:0] snap_id, got_id;
        logic [7:0]    snap_len;
        logic [1:0]    got_resp;
        v = vecs[vi];
        len_i = 32'(v.len);
        {cyc, lat, done_lat, beats, sidx, aw_cnt, dones} = '0;
        {aw_bad, w_bad, data_bad, last_bad, rdy_bad, b_bad} = '0;
        {started, aw_done, aw_pend, b_done, finished} = '0;
        snap_addr = '0; snap_id = '0; snap_len = '0; got_id = '0; got_resp = '0;

        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = v.addr;
        bus.cmd_id    = v.id;
        bus.cmd_len   = v.len;
        bus.BVALID    = 1'b0;
        bus.BID       = v.bid;
        bus.BRESP     = v.bresp;
        bus.AWREADY   = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.WREADY    = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.src_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.src_data  = bus.src_valid ? gen_data(vi, 0) : 32'hDEAD_BEEF;
        bus.src_strb  = bus.src_valid ? gen_strb(vi, 0) : '1;

        while (!finished && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (started) lat++;
            if (!started && bus.cmd_valid && bus.cmd_ready) begin
                started = 1'b1;
                lat = 0;
            end else if (started && bus.cmd_ready && !bus.done && dones == 0) begin
                rdy_bad++;
            end

            aw_hs = 1'b0;
            if (aw_pend) begin
                if (!bus.AWVALID || bus.AWADDR !== snap_addr || bus.AWID !== snap_id ||
                    bus.AWLEN !== snap_len) aw_bad++;
                aw_pend = 1'b0;
            end
            if (bus.AWVALID) begin
                if (bus.AWSIZE !== 3'd2 || bus.AWBURST !== 2'b01) aw_bad++;
                if (bus.AWADDR !== v.addr || bus.AWID !== v.id || bus.AWLEN !== v.len) aw_bad++;
                if (bus.AWREADY) begin
                    aw_cnt++;
                    aw_hs = 1'b1;
                end else begin
                    aw_pend   = 1'b1;
                    snap_addr = bus.AWADDR;
                    snap_id   = bus.AWID;
                    snap_len  = bus.AWLEN;
                end
            end

            in_data = aw_done && beats <= len_i;
            if (bus.WVALID !== (in_data && bus.src_valid)) w_bad++;
            if (bus.src_ready !== (in_data && bus.WREADY)) w_bad++;
            if (bus.WLAST !== (in_data && beats == len_i)) last_bad++;
            if (bus.BREADY !== (aw_done && beats > len_i && !b_done)) b_bad++;
            w_hs   = bus.WVALID && bus.WREADY;
            src_hs = bus.src_valid && bus.src_ready;
            b_hs   = bus.BVALID && bus.BREADY;
            if (w_hs) begin
                if (bus.WDATA !== gen_data(vi, beats) || bus.WSTRB !== gen_strb(vi, beats))
                    data_bad++;
                beats++;
            end

            if (bus.done) begin
                dones++;
                got_id   = bus.done_id;
                got_resp = bus.done_resp;
                done_lat = lat;
                if (dones > 1) finished = 1'b1;
            end else if (dones > 0) begin
                finished = 1'b1;
            end

            @(posedge CLK); #1;
            if (aw_hs) aw_done = 1'b1;
            if (src_hs) sidx++;
            if (w_hs && beats == len_i + 1) bus.BVALID = 1'b1;
            if (b_hs) begin
                bus.BVALID = 1'b0;
                b_done = 1'b1;
            end
            if (started) begin
                if (v.junk_cmd && !b_done) begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_id    = v.id ^ 4'h1;
                    bus.cmd_addr  = ~v.addr;
                    bus.cmd_len   = v.len + 8'd1;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            bus.AWREADY   = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.WREADY    = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.src_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.src_data  = bus.src_valid ? gen_data(vi, sidx) : 32'hDEAD_BEEF;
            bus.src_strb  = bus.src_valid ? gen_strb(vi, sidx) : '1;
        end

        check($sformatf("v%0d completed", vi), 64'(finished), 64'd1);
        check($sformatf("v%0d aw_count", vi), 64'(aw_cnt), 64'd1);
        check($sformatf("v%0d aw_fields", vi), 64'(aw_bad), 64'd0);
        check($sformatf("v%0d w_gating", vi), 64'(w_bad), 64'd0);
        check($sformatf("v%0d w_data", vi), 64'(data_bad), 64'd0);
        check($sformatf("v%0d wlast", vi), 64'(last_bad), 64'd0);
        check($sformatf("v%0d bready", vi), 64'(b_bad), 64'd0);
        check($sformatf("v%0d cmd_ready_busy", vi), 64'(rdy_bad), 64'd0);
        check($sformatf("v%0d beats", vi), 64'(beats), 64'(v.exp_beats));
        check($sformatf("v%0d done_pulses", vi), 64'(dones), 64'd1);
        check($sformatf("v%0d done_id", vi), 64'(got_id), 64'(v.id));
        check($sformatf("v%0d done_resp", vi), 64'(got_resp), 64'(v.exp_resp));
        if (v.exp_lat != 0)
            check($sformatf("v%0d latency", vi), 64'(done_lat), 64'(v.exp_lat));
        idle_inputs();
    endtask

    // ph 0: reset while AWVALID waits, 1: while beat 2 is on W, 2: while BREADY waits
    task automatic reset_in_phase(input int unsigned ph);
        int unsigned n, beats, nd;
        bit hit;
        n = 0; beats = 0; nd = 0; hit = 1'b0;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h300 + ph;
        bus.cmd_id    = 4'd6;
        bus.cmd_len   = 8'd7;
        bus.AWREADY   = (ph != 0);
        bus.WREADY    = 1'b1;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'h1234_5678;
        bus.src_strb  = '1;
        bus.BVALID    = 1'b0;
        while (!hit && n < 50) begin
            @(negedge CLK);
            n++;
            if (bus.done) nd++;
            case (ph)
                0:       hit = bus.AWVALID;
                1: begin
                    if (bus.WVALID && bus.WREADY) beats++;
                    hit = (beats == 2);
                end
                default: hit = bus.BREADY;
            endcase
        end
        check($sformatf("rst%0d reached_phase", ph), 64'(hit), 64'd1);
        bus.cmd_valid = 1'b0;
        RST = 1'b1;
        #1;
        check($sformatf("rst%0d awvalid", ph), 64'(bus.AWVALID), 64'd0);
        check($sformatf("rst%0d wvalid", ph), 64'(bus.WVALID), 64'd0);
        check($sformatf("rst%0d bready", ph), 64'(bus.BREADY), 64'd0);
        check($sformatf("rst%0d cmd_ready", ph), 64'(bus.cmd_ready), 64'd0);
        check($sformatf("rst%0d done_id", ph), 64'(bus.done_id), 64'd0);
        check($sformatf("rst%0d done_resp", ph), 64'(bus.done_resp), 64'd0);
        idle_inputs();
        repeat (2) begin
            @(negedge CLK);
            if (bus.done) nd++;
        end
        RST = 1'b0;
        #1;
        check($sformatf("rst%0d cmd_ready_at_release", ph), 64'(bus.cmd_ready), 64'd0);
        @(negedge CLK);
        if (bus.done) nd++;
        check($sformatf("rst%0d cmd_ready_rise", ph), 64'(bus.cmd_ready), 64'd1);
        check($sformatf("rst%0d no_done", ph), 64'(nd), 64'd0);
    endtask

    initial begin
        idle_inputs();
        //                addr           id     len      bid    bresp  stl   junk  beats lat  resp
        vecs[0] = '{32'h0000_0100, 4'd3,  8'd3,   4'd3,  2'd0, 1'b0, 1'b0, 4,    7,   2'd0};
        vecs[1] = '{32'h0000_2000, 4'd1,  8'd0,   4'd1,  2'd0, 1'b0, 1'b0, 1,    4,   2'd0};
        vecs[2] = '{32'h0001_0000, 4'd9,  8'd255, 4'd9,  2'd0, 1'b0, 1'b0, 256,  259, 2'd0};
        vecs[3] = '{32'h0000_0400, 4'd3,  8'd7,   4'd3,  2'd0, 1'b1, 1'b0, 8,    0,   2'd0};
        vecs[4] = '{32'h0000_0500, 4'd3,  8'd1,   4'd5,  2'd0, 1'b0, 1'b0, 2,    5,   2'd2};
        vecs[5] = '{32'h0000_0600, 4'd3,  8'd1,   4'd3,  2'd2, 1'b0, 1'b0, 2,    5,   2'd2};
        vecs[6] = '{32'h0000_0700, 4'd2,  8'd2,   4'd2,  2'd1, 1'b0, 1'b1, 3,    6,   2'd1};
        vecs[7] = '{32'h0000_0800, 4'd15, 8'd4,   4'd15, 2'd3, 1'b1, 1'b1, 5,    0,   2'd3};
        vecs[8] = '{32'h0000_0900, 4'd6,  8'd7,   4'd6,  2'd0, 1'b1, 1'b0, 8,    0,   2'd0};

        @(negedge CLK);
        check("reset cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("reset awvalid", 64'(bus.AWVALID), 64'd0);
        check("reset wvalid", 64'(bus.WVALID), 64'd0);
        check("reset wlast", 64'(bus.WLAST), 64'd0);
        check("reset src_ready", 64'(bus.src_ready), 64'd0);
        check("reset bready", 64'(bus.BREADY), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset done_resp", 64'(bus.done_resp), 64'd0);
        check("reset done_id", 64'(bus.done_id), 64'd0);
        RST = 1'b0;
        #1;
        check("release cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge CLK);
        check("first cycle cmd_ready", 64'(bus.cmd_ready), 64'd1);

        for (int unsigned i = 0; i < NVEC; i++) run_burst(i);

        for (int unsigned p = 0; p < 3; p++) begin
            reset_in_phase(p);
            run_burst(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/axi4_master_write_engine.md
AXI4_MASTER_WRITE_ENGINE -- requirements
Module: axi4_master_write_engine

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 32, address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, data width; legal values are 8/16/32/64/128.
REQ-003 The block SHALL expose parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and RST as elsewhere in the codebase.
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 cmd_valid  input  1  burst command valid.
REQ-008 cmd_ready  output  1  engine accepts a command.
REQ-009 cmd_addr  input  ADDR_WIDTH  burst start address.
REQ-010 cmd_id  input  ID_WIDTH  burst ID.
REQ-011 cmd_len  input  8  beats minus one.
REQ-012 src_valid  input  1  write-data source beat valid.
REQ-013 src_ready  output  1  engine consumes the source beat.
REQ-014 src_data  input  DATA_WIDTH  source beat data.
REQ-015 src_strb  input  DATA_WIDTH/8  source beat byte enables.
REQ-016 done  output  1  one-cycle pulse when the burst response is received.
REQ-017 done_resp  output  2  final response code.
REQ-018 done_id  output  ID_WIDTH  ID of the completed burst.
REQ-019 AWVALID/AWREADY/AWADDR/AWID/AWLEN  out/in/out/out/out  1/1/ADDR_WIDTH/ID_WIDTH/8  AXI4 write-address channel.
REQ-020 AWSIZE/AWBURST  output  3/2  constant $clog2(DATA_WIDTH/8) / 2'b01 (INCR).
REQ-021 WVALID/WREADY/WDATA/WSTRB/WLAST  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  AXI4 write-data channel.
REQ-022 BVALID/BREADY/BID/BRESP  in/out/in/in  1/1/ID_WIDTH/2  AXI4 write-response channel.

Function
REQ-023 The FSM SHALL have four states: IDLE, ADDR, DATA and RESP.
REQ-024 IDLE SHALL drive cmd_ready=1; on cmd_valid&cmd_ready it SHALL latch addr/id/len, load beats_left=cmd_len, and enter ADDR with AWVALID=1 on the next cycle.
REQ-025 ADDR SHALL hold AWVALID and all AW* fields stable until AWREADY; on AWVALID&AWREADY it SHALL deassert AWVALID and enter DATA on the next cycle.
REQ-026 DATA SHALL route combinationally: WVALID=src_valid, src_ready=WREADY, WDATA=src_data, WSTRB=src_strb, WLAST=(beats_left==0).
REQ-027 Each WVALID&WREADY in DATA SHALL decrement beats_left; the handshake carrying WLAST SHALL enter RESP.
REQ-028 Outside DATA, the block SHALL hold WVALID=0, src_ready=0 and WLAST=0; a stalled source or slave SHALL neither lose nor duplicate beats.
REQ-029 RESP SHALL drive BREADY=1; on BVALID it SHALL pulse done for one cycle with done_id=latched id and done_resp=BRESP, then return to IDLE.
REQ-030 If BID differs from the latched id, done_resp SHALL be 2'b10 (SLVERR) regardless of BRESP.
REQ-031 cmd_len=0 SHALL produce one beat with WLAST; cmd_len=255 SHALL produce 256 beats with no counter wrap before WLAST.
REQ-032 cmd_valid while not in IDLE SHALL be ignored, since cmd_ready=0; there is no command queueing.
REQ-033 Minimum burst cost SHALL be cmd_len+4 cycles from cmd handshake to done, with zero-wait slave and source.
REQ-034 The engine SHALL NOT check 4 KB crossings; the issuer guarantees legal bursts.

Reset
REQ-035 RST high SHALL immediately force IDLE, AWVALID=0, WVALID=0, BREADY=0, done=0, cmd_ready=0, done_resp=0, done_id=0 and beats_left=0; cmd_ready SHALL rise the first cycle after RST falls.
REQ-036 Reset mid-burst SHALL abandon the transaction without a done pulse.

Verification
REQ-037 cmd addr=0x100, id=3, len=3, zero-wait slave -> AW once, 4 W beats, WLAST on beat 4 only, done=1 with id=3, resp=0 at 7 cycles after cmd.
REQ-038 len=0 -> single W beat with WLAST=1; len=255 -> exactly 256 beats, WLAST on beat 256.
REQ-039 Random AWREADY/WREADY/src_valid stalls on len=7 -> data/strb sequence at slave equals source sequence, AW fields stable while AWVALID unacknowledged.
REQ-040 BVALID with BID=5 for burst id=3 and BRESP=0 -> done_resp=2'b10; BRESP=2'b10 with matching BID -> done_resp=2'b10.
REQ-041 RST asserted during beat 2 of len=7 -> WVALID/AWVALID/BREADY drop asynchronously, no done pulse, next command completes normally.
